// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, instruction field positions and datapath width.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int REG_AW   = 5;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // Opcodes whose rt field is a source operand rather than a destination
   function automatic logic readsRt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// MIPS general register file: two combinational read ports, one synchronous write port,
// R0 hardwired to zero, synchronous active-low clear.
module reg_file_32x32
   import mips_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != REG_ZERO)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage feeding the ALU: register file, ID/EX register, load-use hazard,
// valid/ready backpressure and flush. Define ID_WB_BYPASS_EN to forward same-cycle WB data.
module id_operand_stage
   import mips_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [31:0]       in_instr,
   output logic              in_ready,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [DATA_W-1:0] out_reg_a,
   output logic [DATA_W-1:0] out_reg_b
);

   logic              outValid_q, outValid_d;
   logic [31:0]       outInstr_q, outInstr_d;
   logic [DATA_W-1:0] regA_q, regA_d;
   logic [DATA_W-1:0] regB_q, regB_d;

   logic [5:0]        inOp, heldOp;
   logic [REG_AW-1:0] inRs, inRt, heldRs, heldRt;
   logic [DATA_W-1:0] rdA, rdB, opA, opB;
   logic              hazard, load, wbHit;

   assign inOp   = in_instr[OP_MSB:OP_LSB];
   assign inRs   = in_instr[RS_MSB:RS_LSB];
   assign inRt   = in_instr[RT_MSB:RT_LSB];
   assign heldOp = outInstr_q[OP_MSB:OP_LSB];
   assign heldRs = outInstr_q[RS_MSB:RS_LSB];
   assign heldRt = outInstr_q[RT_MSB:RT_LSB];

   reg_file_32x32 #(.NUM_REGS(NUM_REGS)) u_regs (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (wb_en),
      .waddr_i   (wb_addr),
      .wdata_i   (wb_data),
      .raddr_a_i (inRs),
      .raddr_b_i (inRt),
      .rdata_a_o (rdA),
      .rdata_b_o (rdB)
   );

   // A held lw whose destination feeds the incoming instruction forces a one-cycle bubble
   assign hazard = outValid_q && (heldOp == OP_LW) && (heldRt != REG_ZERO) &&
                   ((heldRt == inRs) || ((heldRt == inRt) && readsRt(inOp)));

   assign in_ready = rst_n && (!outValid_q || out_ready) && !hazard && !flush;
   assign load     = in_valid && in_ready;
   assign wbHit    = wb_en && (wb_addr != REG_ZERO);

`ifdef ID_WB_BYPASS_EN
   assign opA = (wbHit && (wb_addr == inRs)) ? wb_data : rdA;
   assign opB = (wbHit && (wb_addr == inRt)) ? wb_data : rdB;
`else
   assign opA = rdA;
   assign opB = rdB;
`endif

   always_comb begin
      outValid_d = outValid_q;
      outInstr_d = outInstr_q;
      regA_d     = regA_q;
      regB_d     = regB_q;
      if (load) begin
         outValid_d = 1'b1;
         outInstr_d = in_instr;
         regA_d     = opA;
         regB_d     = opB;
      end else if (flush || (outValid_q && out_ready)) begin
         outValid_d = 1'b0;
      end else if (outValid_q) begin
         // Stalled instruction picks up late writebacks so EX never sees a stale operand
         if (wbHit && (wb_addr == heldRs)) regA_d = wb_data;
         if (wbHit && (wb_addr == heldRt)) regB_d = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         outInstr_q <= '0;
         regA_q     <= '0;
         regB_q     <= '0;
      end else begin
         outValid_q <= outValid_d;
         outInstr_q <= outInstr_d;
         regA_q     <= regA_d;
         regB_q     <= regB_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_instr = outInstr_q;
   assign out_reg_a = regA_q;
   assign out_reg_b = regB_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomised and directed bench for id_operand_stage against a behavioural pipeline-register model.
// Expectations follow ID_WB_BYPASS_EN when it is defined.
module tb_id_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_reg_a;
   logic [31:0] out_reg_b;

   int testCount = 0;
   int failCount = 0;

   logic [31:0] mRegs [32];
   logic        mValid = 1'b0;
   logic [31:0] mInstr = '0;
   logic [31:0] mA = '0;
   logic [31:0] mB = '0;

   always #5 clk = ~clk;

   id_operand_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .flush     (flush),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_reg_a (out_reg_a),
      .out_reg_b (out_reg_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // A held lw stalls any next instruction that sources its destination register
   function automatic logic modelHazard(input logic [31:0] instr);
      logic [4:0] ldRt;
      logic [5:0] op;
      logic       srcRt;
      ldRt  = mInstr[20:16];
      op    = instr[31:26];
      srcRt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);
      return mValid && (mInstr[31:26] == 6'h23) && (ldRt != 5'd0) &&
             ((ldRt == instr[25:21]) || ((ldRt == instr[20:16]) && srcRt));
   endfunction

   function automatic logic [31:0] readOperand(input logic [4:0] a, input logic wbE,
                                               input logic [4:0] wbA, input logic [31:0] wbD);
`ifdef ID_WB_BYPASS_EN
      if (wbE && (wbA != 5'd0) && (wbA == a)) return wbD;
`endif
      return (a == 5'd0) ? 32'd0 : mRegs[a];
   endfunction

   // One clock: drive at negedge, check in_ready, advance the model across the edge, check outputs
   task automatic applyStimulus(input logic rstN, input logic inV, input logic [31:0] instr,
                                input logic fl, input logic wbE, input logic [4:0] wbA,
                                input logic [31:0] wbD, input logic oRdy);
      logic        expReady, doLoad, nV;
      logic [31:0] nI, nA, nB;
      @(negedge clk);
      rst_n = rstN; in_valid = inV; in_instr = instr; flush = fl;
      wb_en = wbE; wb_addr = wbA; wb_data = wbD; out_ready = oRdy;
      #1;
      expReady = rstN && (!mValid || oRdy) && !modelHazard(instr) && !fl;
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
      doLoad = inV && expReady;
      nV = mValid; nI = mInstr; nA = mA; nB = mB;
      if (!rstN) begin
         nV = 1'b0; nI = '0; nA = '0; nB = '0;
      end else if (doLoad) begin
         nV = 1'b1; nI = instr;
         nA = readOperand(instr[25:21], wbE, wbA, wbD);
         nB = readOperand(instr[20:16], wbE, wbA, wbD);
      end else if (fl || (mValid && oRdy)) begin
         nV = 1'b0;
      end else if (mValid && wbE && (wbA != 5'd0)) begin
         if (wbA == mInstr[25:21]) nA = wbD;
         if (wbA == mInstr[20:16]) nB = wbD;
      end
      @(posedge clk);
      mValid = nV; mInstr = nI; mA = nA; mB = nB;
      if (!rstN) begin
         for (int i = 0; i < 32; i++) mRegs[i] = '0;
      end else if (wbE && (wbA != 5'd0)) begin
         mRegs[wbA] = wbD;
      end
      #1;
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, mValid});
      checkOutput("out_instr", out_instr, mInstr);
      checkOutput("out_reg_a", out_reg_a, mA);
      checkOutput("out_reg_b", out_reg_b, mB);
   endtask

   function automatic logic [31:0] randInstr();
      logic [5:0] op;
      case ($urandom_range(0, 5))
         0, 1:    op = 6'h00;
         2:       op = 6'h23;
         3:       op = 6'h2b;
         4:       op = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
         default: op = 6'h08;
      endcase
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
   endfunction

   initial begin
      logic [31:0] oldR10;
      for (int i = 0; i < 32; i++) mRegs[i] = '0;

      // Reset held two cycles, even with a writeback and an instruction on the inputs
      applyStimulus(1'b0, 1'b1, 32'h00A00820, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h00A00820, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
      checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_reg_a", out_reg_a, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h00A00820, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("add_reg_a", out_reg_a, 32'h0000_1234);
      checkOutput("add_reg_b", out_reg_b, 32'h0);

      // R0 must stay zero
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h00000820, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("r0_reg_a", out_reg_a, 32'h0);

      // lw $2,0($3) then add $4,$2,$2: one bubble, then the add loads
      applyStimulus(1'b1, 1'b1, 32'h8C620000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h00422020, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("hazard_bubble", {31'b0, out_valid}, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h00422020, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("hazard_add_instr", out_instr, 32'h00422020);

      // sub $6,$7,$8 held under backpressure while R8 is written
      applyStimulus(1'b1, 1'b1, 32'h00E83022, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h00A00820, 1'b0, 1'b1, 5'd8, 32'h0000_0010, 1'b0);
      checkOutput("hold_instr", out_instr, 32'h00E83022);
      checkOutput("hold_refresh_b", out_reg_b, 32'h0000_0010);
      checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);

      // Flush with an incoming instruction and a concurrent write of R9
      applyStimulus(1'b1, 1'b1, 32'h00A00820, 1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b1);
      checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h01200820, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("flush_r9_read", out_reg_a, 32'h0000_0099);

      // Same-cycle writeback and read of R10
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd10, 32'h0000_5555, 1'b1);
      oldR10 = 32'h0000_5555;
      applyStimulus(1'b1, 1'b1, 32'h01400820, 1'b0, 1'b1, 5'd10, 32'h0000_ABCD, 1'b1);
`ifdef ID_WB_BYPASS_EN
      checkOutput("same_cycle_r10", out_reg_a, 32'h0000_ABCD);
`else
      checkOutput("same_cycle_r10", out_reg_a, oldR10);
`endif
      applyStimulus(1'b1, 1'b1, 32'h01400820, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("r10_after_write", out_reg_a, 32'h0000_ABCD);

      for (int n = 0; n < 800; n++) begin
         applyStimulus(($urandom_range(0, 99) != 0),
                       ($urandom_range(0, 3) != 0),
                       randInstr(),
                       ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 1) != 0),
                       5'($urandom_range(0, 7)),
                       32'($urandom),
                       ($urandom_range(0, 2) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
